order_dispatcher: RTL and testbench

ORDER_DISPATCHER -- requirements
Module: order_dispatcher

---
 rtl/order_dispatcher_pkg.sv | 25 ++
 rtl/order_dispatcher.sv | 151 +++++++++++++++
 tb/tb_order_dispatcher.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/order_dispatcher_pkg.sv
// Shared definitions for the order dispatcher: FSM states, packet byte codes
// and the packet checksum helper.
package order_dispatcher_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        SIDE,
        PRICE,
        CSUM,
        COOL
    } state_e;

    localparam logic [BYTE_W-1:0] HDR_BYTE  = 8'hA5;
    localparam logic [BYTE_W-1:0] SIDE_BUY  = 8'h01;
    localparam logic [BYTE_W-1:0] SIDE_SELL = 8'h02;

    function automatic logic [BYTE_W-1:0] pkt_csum(input logic [BYTE_W-1:0] side,
                                                   input logic [BYTE_W-1:0] price);
        return HDR_BYTE ^ side ^ price;
    endfunction

endpackage

// File: rtl/order_dispatcher.sv
// Turns buy/sell decision edges into 4-byte order packets on a valid/ready
// byte stream, tracking net position and counting rejected decisions.
module order_dispatcher
    import order_dispatcher_pkg::*;
#(
    parameter int unsigned MAX_POS  = 4,
    parameter int unsigned COOLDOWN = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              buy_signal,
    input  logic              sell_signal,
    input  logic [BYTE_W-1:0] current_data,
    input  logic              tx_ready,
    output logic [BYTE_W-1:0] tx_data,
    output logic              tx_valid,
    output logic              busy,
    output logic [BYTE_W-1:0] position,
    output logic [BYTE_W-1:0] drop_count
);

    localparam logic [BYTE_W-1:0] POS_MAX   = BYTE_W'(MAX_POS);
    localparam logic [BYTE_W-1:0] POS_MIN   = ~POS_MAX + 8'd1;
    localparam logic [BYTE_W-1:0] COOL_LAST = BYTE_W'((COOLDOWN == 0) ? 0 : COOLDOWN - 1);
    localparam logic [BYTE_W-1:0] DROP_SAT  = 8'hFF;

    state_e            state_q, state_d;
    logic              buy_prev_q, sell_prev_q;
    logic [BYTE_W-1:0] side_q, side_d;
    logic [BYTE_W-1:0] price_q, price_d;
    logic [BYTE_W-1:0] cool_cnt_q, cool_cnt_d;
    logic [BYTE_W-1:0] pos_q, pos_d;
    logic [BYTE_W-1:0] drop_q, drop_d;
    logic [BYTE_W-1:0] tx_data_q, tx_data_d;
    logic              tx_valid_q, tx_valid_d;
    logic              busy_q, busy_d;

    logic buy_edge, sell_edge, drop_inc;

    assign buy_edge  = buy_signal & ~buy_prev_q;
    assign sell_edge = sell_signal & ~sell_prev_q;

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            buy_prev_q  <= 1'b0;
            sell_prev_q <= 1'b0;
            side_q      <= '0;
            price_q     <= '0;
            cool_cnt_q  <= '0;
            pos_q       <= '0;
            drop_q      <= '0;
            tx_data_q   <= '0;
            tx_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            buy_prev_q  <= buy_signal;
            sell_prev_q <= sell_signal;
            side_q      <= side_d;
            price_q     <= price_d;
            cool_cnt_q  <= cool_cnt_d;
            pos_q       <= pos_d;
            drop_q      <= drop_d;
            tx_data_q   <= tx_data_d;
            tx_valid_q  <= tx_valid_d;
            busy_q      <= busy_d;
        end
    end

    // Next state, packet sequencing, position and drop accounting
    always_comb begin
        state_d    = state_q;
        side_d     = side_q;
        price_d    = price_q;
        cool_cnt_d = cool_cnt_q;
        pos_d      = pos_q;
        drop_d     = drop_q;
        drop_inc   = 1'b0;
        tx_valid_d = 1'b0;
        tx_data_d  = '0;

        case (state_q)
            IDLE: begin
                if (buy_edge && sell_edge) begin
                    drop_inc = 1'b1;
                end else if (buy_edge) begin
                    if (pos_q == POS_MAX) begin
                        drop_inc = 1'b1;
                    end else begin
                        side_d  = SIDE_BUY;
                        price_d = current_data;
                        state_d = HDR;
                    end
                end else if (sell_edge) begin
                    if (pos_q == POS_MIN) begin
                        drop_inc = 1'b1;
                    end else begin
                        side_d  = SIDE_SELL;
                        price_d = current_data;
                        state_d = HDR;
                    end
                end
            end
            HDR:   if (tx_ready) state_d = SIDE;
            SIDE:  if (tx_ready) state_d = PRICE;
            PRICE: if (tx_ready) state_d = CSUM;
            CSUM: begin
                if (tx_ready) begin
                    pos_d      = (side_q == SIDE_BUY) ? pos_q + 8'd1 : pos_q - 8'd1;
                    cool_cnt_d = '0;
                    state_d    = (COOLDOWN == 0) ? IDLE : COOL;
                end
            end
            COOL: begin
                if (cool_cnt_q == COOL_LAST) begin
                    state_d = IDLE;
                end else begin
                    cool_cnt_d = cool_cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_q != IDLE && (buy_edge || sell_edge)) begin
            drop_inc = 1'b1;
        end
        if (drop_inc && drop_q != DROP_SAT) begin
            drop_d = drop_q + 8'd1;
        end

        // Outputs are decoded from the next state so they register in step with it
        case (state_d)
            HDR:   begin tx_valid_d = 1'b1; tx_data_d = HDR_BYTE;                  end
            SIDE:  begin tx_valid_d = 1'b1; tx_data_d = side_d;                    end
            PRICE: begin tx_valid_d = 1'b1; tx_data_d = price_d;                   end
            CSUM:  begin tx_valid_d = 1'b1; tx_data_d = pkt_csum(side_d, price_d); end
            default: begin tx_valid_d = 1'b0; tx_data_d = '0;                      end
        endcase
    end

    assign busy_d = (state_d != IDLE);

    assign tx_data    = tx_data_q;
    assign tx_valid   = tx_valid_q;
    assign busy       = busy_q;
    assign position   = pos_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_order_dispatcher.sv
// Bench for order_dispatcher: directed scenarios plus random traffic checked
// cycle by cycle against a packet-queue reference model.
module tb_order_dispatcher;

    localparam int MAX_POS  = 4;
    localparam int COOLDOWN = 8;

    logic       clk;
    logic       rst;
    logic       buy_signal;
    logic       sell_signal;
    logic [7:0] current_data;
    logic       tx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       busy;
    logic [7:0] position;
    logic [7:0] drop_count;

    order_dispatcher #(.MAX_POS(MAX_POS), .COOLDOWN(COOLDOWN)) dut (
        .clk          (clk),
        .rst          (rst),
        .buy_signal   (buy_signal),
        .sell_signal  (sell_signal),
        .current_data (current_data),
        .tx_ready     (tx_ready),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .busy         (busy),
        .position     (position),
        .drop_count   (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert;
    int n_fail;

    // Reference model: bytes still to send, cooldown cycles left, net position
    logic [7:0] m_pkt[$];
    int         m_cool;
    int         m_pos;
    int         m_dir;
    int         m_drop;
    logic       m_pb;
    logic       m_ps;

    logic [7:0] got[$];
    int         busy_cycles;
    bit         valid_seen;
    logic [7:0] exp_bytes[4];

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pkt.delete();
        m_cool = 0;
        m_pos  = 0;
        m_dir  = 0;
        m_drop = 0;
        m_pb   = 1'b0;
        m_ps   = 1'b0;
    endtask

    task automatic model_drop();
        if (m_drop < 255) m_drop++;
    endtask

    task automatic model_start(input logic [7:0] code, input logic [7:0] price, input int dir);
        m_pkt.push_back(8'hA5);
        m_pkt.push_back(code);
        m_pkt.push_back(price);
        m_pkt.push_back(8'hA5 ^ code ^ price);
        m_dir = dir;
    endtask

    task automatic model_edge(input logic b, input logic s, input logic [7:0] d, input logic r);
        logic       be;
        logic       se;
        logic [7:0] sent;
        be = b && !m_pb;
        se = s && !m_ps;
        if (m_pkt.size() != 0 || m_cool != 0) begin
            if (be || se) model_drop();
            if (m_pkt.size() != 0) begin
                if (r) begin
                    sent = m_pkt.pop_front();
                    if (m_pkt.size() == 0) begin
                        m_pos += m_dir;
                        m_cool = COOLDOWN;
                    end
                end
            end else begin
                m_cool--;
            end
        end else if (be && se) begin
            model_drop();
        end else if (be) begin
            if (m_pos == MAX_POS) model_drop();
            else model_start(8'h01, d, 1);
        end else if (se) begin
            if (m_pos == -MAX_POS) model_drop();
            else model_start(8'h02, d, -1);
        end
        m_pb = b;
        m_ps = s;
    endtask

    task automatic check_all(input string pfx);
        chk({pfx, ".tx_valid"}, 8'(tx_valid), 8'(m_pkt.size() != 0));
        chk({pfx, ".tx_data"}, tx_data, (m_pkt.size() != 0) ? m_pkt[0] : 8'h00);
        chk({pfx, ".busy"}, 8'(busy), 8'(m_pkt.size() != 0 || m_cool != 0));
        chk({pfx, ".position"}, position, 8'(m_pos));
        chk({pfx, ".drop_count"}, drop_count, 8'(m_drop));
    endtask

    // One clock: drive inputs, capture the byte accepted at this edge, check after it
    task automatic step(input logic b, input logic s, input logic [7:0] d, input logic r);
        buy_signal   = b;
        sell_signal  = s;
        current_data = d;
        tx_ready     = r;
        if (tx_valid === 1'b1 && r) got.push_back(tx_data);
        @(posedge clk);
        model_edge(b, s, d, r);
        #1;
        if (busy === 1'b1) busy_cycles++;
        if (tx_valid === 1'b1) valid_seen = 1'b1;
        check_all("cyc");
    endtask

    task automatic apply_reset(input int cycles);
        rst         = 1'b1;
        buy_signal  = 1'b0;
        sell_signal = 1'b0;
        tx_ready    = 1'b0;
        #1;
        model_reset();
        check_all("rst_now");
        repeat (cycles) @(posedge clk);
        #1;
        check_all("rst_hold");
        rst = 1'b0;
        got.delete();
        busy_cycles = 0;
        valid_seen  = 1'b0;
    endtask

    task automatic chk_got(input string tag);
        chk({tag, ".count"}, 8'(got.size()), 8'd4);
        for (int i = 0; i < 4; i++) begin
            chk({tag, ".byte"}, (i < got.size()) ? got[i] : 8'hxx, exp_bytes[i]);
        end
    endtask

    initial begin
        n_assert     = 0;
        n_fail       = 0;
        current_data = 8'h00;
        apply_reset(2);

        // Buy at 0x40 with the sink always ready
        step(1'b1, 1'b0, 8'h40, 1'b1);
        repeat (15) step(1'b0, 1'b0, 8'h00, 1'b1);
        exp_bytes = '{8'hA5, 8'h01, 8'h40, 8'hE4};
        chk_got("buy40");
        chk("buy40.position", position, 8'd1);
        chk("buy40.busy_cycles", 8'(busy_cycles), 8'd12);

        // Sell at 0x10 with the sink stalling every other cycle
        got.delete();
        step(1'b0, 1'b1, 8'h10, 1'b1);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 8'h77, (i % 2) == 1);
        exp_bytes = '{8'hA5, 8'h02, 8'h10, 8'hB7};
        chk_got("sell10");
        chk("sell10.position", position, 8'd0);

        // Five spaced buys against a limit of four
        apply_reset(1);
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 1'b0, 8'(k), 1'b1);
            repeat (19) step(1'b0, 1'b0, 8'h00, 1'b1);
        end
        chk("limit.position", position, 8'd4);
        chk("limit.drop_count", drop_count, 8'd1);

        // Buy and sell rising together
        apply_reset(1);
        step(1'b1, 1'b1, 8'h55, 1'b1);
        repeat (5) step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("conflict.valid_seen", 8'(valid_seen), 8'd0);
        chk("conflict.drop_count", drop_count, 8'd1);

        // Buy edge mid-packet, then a held buy level after returning to idle
        apply_reset(1);
        step(1'b1, 1'b0, 8'h22, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b0, 8'h99, 1'b0);
        repeat (30) step(1'b1, 1'b0, 8'h99, 1'b1);
        exp_bytes = '{8'hA5, 8'h01, 8'h22, 8'h86};
        chk_got("busy_edge");
        chk("busy_edge.drop_count", drop_count, 8'd1);
        chk("busy_edge.position", position, 8'd1);

        // Reset while the price byte is on the bus
        apply_reset(1);
        step(1'b1, 1'b0, 8'h33, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("abort.price_byte", tx_data, 8'h33);
        apply_reset(1);
        chk("abort.position", position, 8'd0);
        step(1'b1, 1'b0, 8'h61, 1'b1);
        repeat (14) step(1'b0, 1'b0, 8'h00, 1'b1);
        exp_bytes = '{8'hA5, 8'h01, 8'h61, 8'hC5};
        chk_got("after_abort");

        // Rapid toggling drives the drop counter into saturation
        apply_reset(1);
        for (int i = 0; i < 800; i++) step((i % 2) == 0, 1'b0, 8'(i), 1'b1);
        chk("sat.drop_count", drop_count, 8'hFF);

        // Random traffic with occasional resets
        apply_reset(1);
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 599) == 0) apply_reset(2);
            step($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
                 8'($urandom), $urandom_range(0, 3) != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
